// File: rtl/regfile_scoreboard.sv
// Parametrised register file with sequential clear, write-to-read bypass,
// hardwired zero register and a per-register pending-write scoreboard.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     dbg_state
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         clr_cnt_q;
  logic [DATA_W-1:0]         regs [NUM_REGS];
  logic [NUM_REGS-1:0]       busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]         rd_busy_q, rd_busy_d;
  logic                      rd_valid_q;
  logic                      run, we_eff, claim_eff;

  assign run       = (state_q == S_RUN);
  assign we_eff    = run && we && !((ZERO_REG != 0) && (waddr == '0));
  assign claim_eff = run && claim_en && !((ZERO_REG != 0) && (claim_addr == '0));

  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && clr_cnt_q == LAST_REG) state_d = S_RUN;
  end

  // Claim is applied after the write so a same-edge claim keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (we_eff)    busy_d[waddr]      = 1'b0;
    if (claim_eff) busy_d[claim_addr] = 1'b1;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              is_zero, bypass;
    assign a       = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (a == '0);
    assign bypass  = we_eff && (waddr == a);
    assign rd_data_d[k*DATA_W +: DATA_W] = is_zero ? '0 : (bypass ? wdata : regs[a]);
    assign rd_busy_d[k] = !is_zero && !bypass && busy_q[a];
  end

  // Contents survive reset; only the clear sequence zeroes them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_CLEAR) regs[clr_cnt_q] <= '0;
      else if (we_eff)        regs[waddr]     <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
      busy_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      rd_valid_q <= run && rd_en;
      if (state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
      if (run && rd_en) begin
        rd_data_q <= rd_data_d;
        rd_busy_q <= rd_busy_d;
      end
    end
  end

  // rd_valid is a one-cycle strobe with no back-pressure: rd_data/rd_busy are
  // meaningful only in the cycle after an accepted rd_en, otherwise they hold.
  assign ready     = run;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_busy   = rd_busy_q;
  assign busy_vec  = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and random checks of regfile_scoreboard against a behavioural
// register-file model (array of values plus pending-write flags).
module tb_regfile_scoreboard;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     ready;
  logic                     rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     claim_en;
  logic [ADDR_W-1:0]        claim_addr;
  logic [NUM_REGS-1:0]      busy_vec;
  logic                     dbg_state;

  // clock/reset block
  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy), .we(we),
    .waddr(waddr), .wdata(wdata), .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_vec(busy_vec), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model
  logic [DATA_W-1:0]   m_regs [NUM_REGS];
  logic                m_pending [NUM_REGS];
  int                  m_cleared;
  logic                m_ready;
  logic                m_rd_valid;
  logic [DATA_W-1:0]   m_rd_data [NUM_RD];
  logic                m_rd_busy [NUM_RD];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] port_addr(input int k);
    return rd_addr[k*ADDR_W +: ADDR_W];
  endfunction

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    int a;
    if (reset) begin
      m_cleared  = 0;
      m_ready    = 1'b0;
      m_rd_valid = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
        m_rd_data[k] = '0;
        m_rd_busy[k] = 1'b0;
      end
      for (int i = 0; i < NUM_REGS; i++) m_pending[i] = 1'b0;
    end else if (!m_ready) begin
      m_regs[m_cleared] = '0;
      m_cleared++;
      m_ready    = (m_cleared == NUM_REGS);
      m_rd_valid = 1'b0;
    end else begin
      m_rd_valid = rd_en;
      if (rd_en) begin
        for (int k = 0; k < NUM_RD; k++) begin
          a = int'(port_addr(k));
          if (a == 0) begin
            m_rd_data[k] = '0;
            m_rd_busy[k] = 1'b0;
          end else if (we && int'(waddr) == a) begin
            m_rd_data[k] = wdata;
            m_rd_busy[k] = 1'b0;
          end else begin
            m_rd_data[k] = m_regs[a];
            m_rd_busy[k] = m_pending[a];
          end
        end
      end
      if (we && waddr != 0) begin
        m_regs[waddr]    = wdata;
        m_pending[waddr] = 1'b0;
      end
      if (claim_en && claim_addr != 0) m_pending[claim_addr] = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [NUM_REGS-1:0] exp_busy;
    for (int i = 0; i < NUM_REGS; i++) exp_busy[i] = m_pending[i];
    check("ready", 64'(ready), 64'(m_ready));
    check("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    check("busy_vec", 64'(busy_vec), 64'(exp_busy));
    for (int k = 0; k < NUM_RD; k++) begin
      check($sformatf("rd_data%0d", k), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(m_rd_data[k]));
      check($sformatf("rd_busy%0d", k), 64'(rd_busy[k]), 64'(m_rd_busy[k]));
    end
  endtask

  // driver tasks
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; rd_en = 1'b0; rd_addr = '0; we = 1'b0; waddr = '0;
    wdata = '0; claim_en = 1'b0; claim_addr = '0;
  endtask

  task automatic set_read(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a0);
    rd_en = 1'b1;
    rd_addr = {a1, a0};
  endtask

  initial begin
    int edges;
    for (int i = 0; i < NUM_REGS; i++) begin
      m_regs[i] = 'x;
      m_pending[i] = 1'b0;
    end
    m_cleared = 0;
    m_ready = 1'b0;
    m_rd_valid = 1'b0;
    idle_inputs();

    // 1: reset, count edges to ready, then all registers read back 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    edges = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      edges = n;
      if (ready === 1'b1) break;
    end
    check("ready_edge", 64'(edges), 64'd32);
    for (int r = 0; r < NUM_REGS; r += 2) begin
      set_read(ADDR_W'(r + 1), ADDR_W'(r));
      tick();
      check("clear_rd_valid", 64'(rd_valid), 64'd1);
      check("clear_rd_data", 64'(rd_data), 64'd0);
    end
    idle_inputs();
    tick();
    check("rd_valid_drop", 64'(rd_valid), 64'd0);

    // 2: write R5 then read {R5,R0}
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    idle_inputs();
    set_read(5'd5, 5'd0);
    tick();
    check("r5_r0_data", 64'(rd_data), {32'hDEADBEEF, 32'h0});
    check("r5_r0_busy", 64'(rd_busy), 64'd0);

    // 3: same-cycle write/read bypass
    idle_inputs();
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    set_read(5'd5, 5'd7);
    tick();
    check("bypass_data", 64'(rd_data[31:0]), 64'h12345678);
    check("bypass_busy", 64'(rd_busy[0]), 64'd0);

    // 4: claim / read busy / write clears / claim wins over write
    idle_inputs();
    claim_en = 1'b1; claim_addr = 5'd9;
    tick();
    check("claim_r9", 64'(busy_vec[9]), 64'd1);
    idle_inputs();
    set_read(5'd0, 5'd9);
    tick();
    check("rd_busy_r9", 64'(rd_busy[0]), 64'd1);
    idle_inputs();
    we = 1'b1; waddr = 5'd9; wdata = 32'h1;
    tick();
    check("write_clears_r9", 64'(busy_vec[9]), 64'd0);
    idle_inputs();
    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    claim_en = 1'b1; claim_addr = 5'd9;
    tick();
    check("claim_wins_r9", 64'(busy_vec[9]), 64'd1);
    idle_inputs();
    set_read(5'd0, 5'd9);
    tick();
    check("r9_updated", 64'(rd_data[31:0]), 64'h55);

    // 5: zero register ignores writes and claims, including bypass
    idle_inputs();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    claim_en = 1'b1; claim_addr = 5'd0;
    set_read(5'd0, 5'd0);
    tick();
    check("r0_busy_vec", 64'(busy_vec[0]), 64'd0);
    check("r0_bypass_blocked", 64'(rd_data), 64'd0);
    idle_inputs();
    set_read(5'd0, 5'd0);
    tick();
    check("r0_reads_zero", 64'(rd_data), 64'd0);

    // 6: reset during a read with state pending
    idle_inputs();
    we = 1'b1; waddr = 5'd3; wdata = 32'hAA;
    claim_en = 1'b1; claim_addr = 5'd4;
    tick();
    check("pre_reset_busy4", 64'(busy_vec[4]), 64'd1);
    idle_inputs();
    set_read(5'd4, 5'd3);
    reset = 1'b1;
    tick();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_busy_vec", 64'(busy_vec), 64'd0);
    idle_inputs();
    repeat (NUM_REGS) tick();
    check("reclear_ready", 64'(ready), 64'd1);
    set_read(5'd4, 5'd3);
    tick();
    check("r3_cleared", 64'(rd_data[31:0]), 64'd0);

    // random traffic, addresses biased to a small set to force collisions
    for (int n = 0; n < 800; n++) begin
      idle_inputs();
      reset      = ($urandom_range(0, 199) == 0);
      rd_en      = $urandom_range(0, 1);
      rd_addr    = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
      if ($urandom_range(0, 3) == 0) rd_addr = NUM_RD*ADDR_W'($urandom);
      we         = $urandom_range(0, 1);
      waddr      = ADDR_W'($urandom_range(0, 7));
      wdata      = $urandom;
      claim_en   = ($urandom_range(0, 2) == 0);
      claim_addr = ADDR_W'($urandom_range(0, 7));
      tick();
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
